// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and defaults for the MIPS data-memory access path.
// Used by mem_access_unit and mem_lane_align.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // Encoding 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory port of the MEM stage.
// master = access unit, slave = memory.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; shared with the instruction-fetch path.
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);
    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        be      = 4'b1111;
        wdata   = st_data;
        shifted = ld_word;
        ld_data = ld_word;
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << lane;
                wdata   = {4{st_data[7:0]}};
                shifted = ld_word >> {lane, 3'b000};
                ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{st_data[15:0]}};
                shifted = ld_word >> {lane[1], 4'b0000};
                ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/REQ/DONE handshake, lane steering, timeout.
// Optional alignment fault detection with `define MEM_ALIGN_CHECK_EN.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,  // must be >= 1
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               mem_size,
    input  logic                     mem_unsigned,
    input  logic [31:0]              addr,
    input  logic [31:0]              wData,
    output logic                     stall,
    output logic [31:0]              rData_mem,
    output logic                     bus_err,
    mem_access_unit_if.master        dmem
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                     misalign
`endif
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [31:0]       addr_q, wdata_q, rdata_q;
    logic [3:0]        be_q;
    logic [1:0]        lane_q, size_q;
    logic              uns_q, we_q, bus_err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              access, mis;
    logic [1:0]        lane_sel, size_sel;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata, lane_rdata;

    assign access = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign mis = access & is_misaligned(mem_size, addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // Live inputs drive store steering in IDLE; captured fields drive load extraction afterwards.
    assign lane_sel = (state_q == ST_IDLE) ? addr[1:0] : lane_q;
    assign size_sel = (state_q == ST_IDLE) ? mem_size  : size_q;

    mem_lane_align u_lane_align (
        .lane        (lane_sel),
        .size        (size_sel),
        .is_unsigned (uns_q),
        .st_data     (wData),
        .ld_word     (dmem.rdata),
        .be          (lane_be),
        .wdata       (lane_wdata),
        .ld_data     (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access) state_d = mis ? ST_DONE : ST_REQ;
            ST_REQ:  if (dmem.ack || cnt_q == CNT_MAX) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access && !mis) begin
                        addr_q  <= {addr[31:2], 2'b00};
                        lane_q  <= addr[1:0];
                        size_q  <= mem_size;
                        uns_q   <= mem_unsigned;
                        we_q    <= MemWrite;
                        be_q    <= lane_be;
                        wdata_q <= lane_wdata;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_REQ: begin
                    if (dmem.ack) begin
                        if (!we_q) rdata_q <= lane_rdata;
                    end else if (cnt_q == CNT_MAX) begin
                        if (!we_q) rdata_q <= ERR_DATA;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= (state_q == ST_IDLE) && mis;
    end

    assign misalign = misalign_q;
`endif

    // Gated by rst so the pipeline is released while reset is held.
    assign stall = ~rst & (((state_q == ST_IDLE) & access) | (state_q == ST_REQ));

    assign dmem.req   = (state_q == ST_REQ);
    assign dmem.we    = dmem.req & we_q;
    assign dmem.addr  = addr_q;
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign rData_mem = rdata_q;
    assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences, random vs model.
module tb_mem_access_unit;
    localparam int TIMEOUT_TB = 4;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        MemRead, MemWrite, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wData, rData_mem;
    logic        stall, bus_err;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    mem_access_unit_if dmem ();

    mem_access_unit #(.TIMEOUT(TIMEOUT_TB), .ERR_DATA(ERR_WORD)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .addr         (addr),
        .wData        (wData),
        .stall        (stall),
        .rData_mem    (rData_mem),
        .bus_err      (bus_err),
        .dmem         (dmem)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign     (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          done;
        int          stall_cycles;
        int          req_cycles;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr, wdata, rdata;
        bit          unstable;
        int          bus_err_cnt;
        int          mis_cnt;
        logic        idle_stall;
        logic [31:0] idle_rdata;
    } obs_t;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a, wd;
        int          ack_at;
        logic [31:0] rword;
        int          exp_stall;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata, exp_rdata;
        int          exp_berr;
    } vec_t;

    vec_t vecs[10];
    logic [31:0] ref_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int first_byte(input logic [31:0] a, input int n);
        return int'(a % 32'd4) / n * n;
    endfunction

    function automatic logic [3:0] ref_be(input logic [31:0] a, input int n);
        logic [3:0] r;
        int lo;
        lo = first_byte(a, n);
        for (int i = 0; i < 4; i++) r[i] = (i >= lo) && (i < lo + n);
        return r;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                             input int n, input logic uns);
        longint v;
        int lo;
        lo = first_byte(a, n);
        v = 0;
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'((word >> (8 * (lo + i))) & 32'hFF);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- transaction driver / monitor ----------------
    task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                           input logic [31:0] rword, input bit noise, output obs_t o);
        o = '{default: 0};
        MemRead = rd; MemWrite = wr; mem_size = sz; mem_unsigned = uns; addr = a; wData = wd;
        for (int cyc = 0; cyc < TIMEOUT_TB + 8; cyc++) begin
            #1;
            if (bus_err) o.bus_err_cnt++;
`ifdef MEM_ALIGN_CHECK_EN
            if (misalign) o.mis_cnt++;
`endif
            if (dmem.req) begin
                o.req_cycles++;
                if (o.req_cycles == 1) begin
                    o.be = dmem.be; o.we = dmem.we; o.addr = dmem.addr; o.wdata = dmem.wdata;
                end else if ({dmem.be, dmem.we, dmem.addr, dmem.wdata} !== {o.be, o.we, o.addr, o.wdata}) begin
                    o.unstable = 1'b1;
                end
                dmem.ack   = (o.req_cycles == ack_at);
                dmem.rdata = dmem.ack ? rword : $urandom;
            end else begin
                dmem.ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                dmem.rdata = $urandom;
            end
            if (stall) o.stall_cycles++;
            else begin
                o.done  = 1'b1;
                o.rdata = rData_mem;
                break;
            end
            @(posedge clk); #1;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk); #1;
        o.idle_stall = stall;
        o.idle_rdata = rData_mem;
    endtask

    task automatic check_txn(input string tag, input obs_t o, input int exp_stall,
                             input logic [3:0] exp_be, input logic exp_we,
                             input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_rd, input int exp_berr, input int exp_mis);
        int exp_req;
        exp_req = (exp_mis != 0) ? 0 : exp_stall - 1;
        check($sformatf("%s done-in-bound", tag), 32'(o.done), 32'd1);
        check($sformatf("%s stall_cycles", tag), 32'(o.stall_cycles), 32'(exp_stall));
        check($sformatf("%s req_cycles", tag), 32'(o.req_cycles), 32'(exp_req));
        if (exp_req > 0) begin
            check($sformatf("%s dmem_be", tag), 32'(o.be), 32'(exp_be));
            check($sformatf("%s dmem_we", tag), 32'(o.we), 32'(exp_we));
            check($sformatf("%s dmem_addr", tag), o.addr, exp_addr);
            check($sformatf("%s dmem_wdata", tag), o.wdata, exp_wdata);
            check($sformatf("%s req_stable", tag), 32'(o.unstable), 32'd0);
        end
        check($sformatf("%s rData_mem", tag), o.rdata, exp_rd);
        check($sformatf("%s bus_err_pulses", tag), 32'(o.bus_err_cnt), 32'(exp_berr));
        check($sformatf("%s idle_stall", tag), 32'(o.idle_stall), 32'd0);
        check($sformatf("%s idle_rData_hold", tag), o.idle_rdata, exp_rd);
`ifdef MEM_ALIGN_CHECK_EN
        check($sformatf("%s misalign_pulses", tag), 32'(o.mis_cnt), 32'(exp_mis));
`endif
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        obs_t        o;
        logic        r_rd, r_wr, r_uns, r_mis, r_hit, r_load;
        logic [1:0]  r_sz;
        logic [31:0] r_a, r_wd, r_word, r_exp;
        int          r_sel, r_ack, r_n, r_len, r_stall;

        //          rd    wr    sz    uns   addr        wData         ack rword          stall be    we    wdata         rData_mem     berr
        vecs[0] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0000_0000, 1, 32'h1234_5678, 2, 4'hF, 1'b0, 32'h0000_0000, 32'h1234_5678, 0};
        vecs[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0000_0000, 1, 32'h80FF_0000, 2, 4'h8, 1'b0, 32'h0000_0000, 32'hFFFF_FF80, 0};
        vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0000_0000, 1, 32'h80FF_0000, 2, 4'h8, 1'b0, 32'h0000_0000, 32'h0000_0080, 0};
        vecs[3] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'hAAAA_BEEF, 1, 32'h5555_5555, 2, 4'hC, 1'b1, 32'hBEEF_BEEF, 32'h0000_0080, 0};
        vecs[4] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h104, 32'h0000_0000, 0, 32'h0000_0000, 5, 4'hF, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 1};
        vecs[5] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0000_0000, 3, 32'h8001_1234, 4, 4'hC, 1'b0, 32'h0000_0000, 32'hFFFF_8001, 0};
        vecs[6] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0000_0000, 4, 32'h8001_F00D, 5, 4'h3, 1'b0, 32'h0000_0000, 32'h0000_F00D, 0};
        vecs[7] = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_00A5, 2, 32'h0000_0000, 3, 4'h2, 1'b1, 32'hA5A5_A5A5, 32'h0000_F00D, 0};
        vecs[8] = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h204, 32'h1122_3344, 1, 32'h9999_9999, 2, 4'hF, 1'b1, 32'h1122_3344, 32'h0000_F00D, 0};
        vecs[9] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h208, 32'h0000_0000, 2, 32'hCAFE_F00D, 3, 4'hF, 1'b0, 32'h0000_0000, 32'hCAFE_F00D, 0};

        rst = 1'b1;
        MemRead = 1'b0; MemWrite = 1'b0; mem_size = 2'd0; mem_unsigned = 1'b0;
        addr = '0; wData = '0;
        dmem.ack = 1'b0; dmem.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset stall", 32'(stall), 32'd0);
        check("reset dmem_req", 32'(dmem.req), 32'd0);
        check("reset dmem_we", 32'(dmem.we), 32'd0);
        check("reset bus_err", 32'(bus_err), 32'd0);
        check("reset dmem_addr", dmem.addr, 32'd0);
        check("reset dmem_be", 32'(dmem.be), 32'd0);
        check("reset dmem_wdata", dmem.wdata, 32'd0);
        check("reset rData_mem", rData_mem, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
        check("reset misalign", 32'(misalign), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
                    vecs[i].ack_at, vecs[i].rword, 1'b0, o);
            check_txn($sformatf("vec%0d", i), o, vecs[i].exp_stall, vecs[i].exp_be, vecs[i].exp_we,
                      {vecs[i].a[31:2], 2'b00}, vecs[i].exp_wdata, vecs[i].exp_rdata,
                      vecs[i].exp_berr, 0);
            ref_r = vecs[i].exp_rdata;
        end

        // lw at 0x101: alignment fault when checking is built in, otherwise forced aligned
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 1, 32'h5A5A_1234, 1'b0, o);
`ifdef MEM_ALIGN_CHECK_EN
        check_txn("misaligned lw", o, 1, 4'hF, 1'b0, 32'h100, 32'h0, ref_r, 0, 1);
`else
        check_txn("unaligned lw", o, 2, 4'hF, 1'b0, 32'h100, 32'h0, 32'h5A5A_1234, 0, 0);
        ref_r = 32'h5A5A_1234;
`endif

        // Reset during the second REQ cycle
        MemRead = 1'b1; MemWrite = 1'b0; mem_size = 2'd2; mem_unsigned = 1'b0;
        addr = 32'h300; wData = '0; dmem.ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst-in-REQ req before", 32'(dmem.req), 32'd1);
        rst = 1'b1;
        #1;
        check("rst-in-REQ dmem_req", 32'(dmem.req), 32'd0);
        check("rst-in-REQ stall", 32'(stall), 32'd0);
        check("rst-in-REQ rData_mem", rData_mem, 32'd0);
        MemRead = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_r = 32'h0;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1, 32'h0BAD_F00D, 1'b0, o);
        check_txn("post-reset lw", o, 2, 4'hF, 1'b0, 32'h300, 32'h0, 32'h0BAD_F00D, 0, 0);
        ref_r = 32'h0BAD_F00D;

        // Random transactions against the byte-level model, with ack noise outside REQ
        for (int k = 0; k < 40; k++) begin
            r_sel  = $urandom_range(0, 2);
            r_rd   = (r_sel != 1);
            r_wr   = (r_sel != 0);
            r_sz   = 2'($urandom_range(0, 3));
            r_uns  = 1'($urandom_range(0, 1));
            r_a    = $urandom;
            r_wd   = $urandom;
            r_word = $urandom;
            r_ack  = $urandom_range(0, TIMEOUT_TB + 1);

            r_n    = nbytes(r_sz);
            r_mis  = ALIGN_EN && ((r_a % r_n) != 0);
            r_hit  = (r_ack >= 1) && (r_ack <= TIMEOUT_TB);
            r_len  = r_mis ? 0 : (r_hit ? r_ack : TIMEOUT_TB);
            r_stall = 1 + r_len;
            r_load = r_rd && !r_wr;
            if (r_mis || !r_load) r_exp = ref_r;
            else if (r_hit)       r_exp = ref_load(r_word, r_a, r_n, r_uns);
            else                  r_exp = ERR_WORD;

            run_txn(r_rd, r_wr, r_sz, r_uns, r_a, r_wd, r_ack, r_word, 1'b1, o);
            check_txn($sformatf("rnd%0d", k), o, r_stall, ref_be(r_a, r_n), r_wr,
                      r_a & 32'hFFFF_FFFC, ref_wdata(r_wd, r_n), r_exp,
                      (!r_mis && !r_hit) ? 1 : 0, r_mis ? 1 : 0);
            ref_r = r_exp;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access stage of the pipelined MIPS CPU: the producer side of the MEM/WB pipeline register. It turns the MEM-stage load/store controls into a request/acknowledge transaction on the data-memory port. It performs byte-lane steering and sign/zero extension, and delivers the load result as `rData_mem` to MEM/WB. It stalls the pipeline while a transaction is outstanding and bounds each transaction with a timeout.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum REQ-state cycles without `dmem_ack` before the transaction is aborted.
- `ERR_DATA`, 32'hDEAD_BEEF: load result returned on timeout.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `MemRead` input 1: load in MEM stage.
- `MemWrite` input 1: store in MEM stage. Wins if both controls are high.
- `mem_size` input 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `mem_unsigned` input 1: zero-extend loads (lbu/lhu).
- `addr` input 32: effective address (ALU result).
- `wData` input 32: store data (rt).
- `stall` output 1: freeze PC/IF/ID/EX/MEM registers and block MEM/WB capture.
- `rData_mem` output 32: extended load data to MEM/WB.
- `bus_err` output 1: one-cycle pulse on timeout.
- `dmem_req` output 1: request valid.
- `dmem_we` output 1: write request.
- `dmem_addr` output 32: `{addr[31:2],2'b00}`.
- `dmem_be` output 4: byte enables; bit i selects bits [8i+7:8i].
- `dmem_wdata` output 32: lane-replicated store data.
- `dmem_ack` input 1: memory completion. Sampled only while `dmem_req` is high.
- `dmem_rdata` input 32: read word, valid with `dmem_ack`.
- `misalign` output 1: alignment fault pulse. Present only with `MEM_ALIGN_CHECK_EN`.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, with `MemRead|MemWrite`:
  - Register `addr`, `mem_size`, `mem_unsigned`, the write flag, `dmem_be` and `dmem_wdata`.
  - Go to REQ.
- IDLE, otherwise: stay in IDLE.
- REQ:
  - `dmem_req` = 1, and all `dmem_*` outputs are held stable.
  - On `dmem_ack`: for a load, capture the extended `dmem_rdata` into `rData_mem`; then go to DONE.
  - Cycle counter reaching `TIMEOUT` without ack: `rData_mem` = `ERR_DATA` for loads, pulse `bus_err`, go to DONE.
- DONE: lasts one cycle and releases the stall, then returns to IDLE. This prevents the held instruction from re-triggering.
- Lane rules (little-endian, lane = `addr[1:0]`):
  - Byte: be = 1<<lane, wdata = `{4{wData[7:0]}}`.
  - Half: be = 0011 if `addr[1]`=0, else 1100; wdata = `{2{wData[15:0]}}`.
  - Word: be = 1111.
- Load extract: shift `dmem_rdata` right by 8*lane (half uses `addr[1]`), then sign-extend, or zero-extend if `mem_unsigned`.
- `rData_mem` changes only on a completed or timed-out load. Stores and idle cycles hold it.
- `stall` = (IDLE & (MemRead|MemWrite)) | REQ. It is combinational and deasserts in DONE.

## Timing
- Reset values: state IDLE; `stall`, `dmem_req`, `dmem_we`, `bus_err`, `misalign` = 0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `rData_mem` = 0; counter 0.
- Minimum latency, with ack in the first REQ cycle: 2 stall cycles (IDLE, REQ), then DONE. MEM/WB captures in the DONE cycle.
- Ack at the REQ cycle where the counter equals `TIMEOUT`: the ack wins and there is no `bus_err`.
- Reset in REQ: `dmem_req` drops immediately (asynchronous) and the transaction is abandoned.
- A `dmem_ack` outside REQ is ignored.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no request.
  - Transition IDLE→DONE with 1 stall cycle and a one-cycle `misalign` pulse in DONE.
  - `rData_mem` is unchanged.
- Not defined: the `misalign` port is absent, and the unused low address bits are ignored (half uses `addr[1]`, word is forced aligned).

## Structure
- Package `mips_mem_pkg`: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state enum, `TIMEOUT` and `ERR_DATA` defaults.
- Sub-module `mem_lane_align`: combinational generation of be and wdata, plus load extraction/extension. It is shared with the instruction-fetch path later.

## Test plan
- lw at 0x100, ack on first REQ cycle with rdata 0x12345678 -> stall 2 cycles, `rData_mem`=0x12345678 in DONE, `dmem_be`=1111.
- lb at 0x103, rdata 0x80FF_0000 -> `rData_mem`=0xFFFFFF80; lbu gives 0x00000080.
- sh at 0x102 with wData 0xAAAA_BEEF -> `dmem_we`=1, `dmem_be`=1100, `dmem_wdata`=0xBEEFBEEF, `rData_mem` unchanged.
- lw with no ack, `TIMEOUT`=4 -> REQ held 4 cycles, `bus_err` pulse, `rData_mem`=0xDEADBEEF, then IDLE.
- `rst` asserted in the second REQ cycle -> `dmem_req`/`stall` low immediately; next load starts from IDLE cleanly.
- `MEM_ALIGN_CHECK_EN`, lw at 0x101 -> no `dmem_req`, 1 stall cycle, `misalign` pulse.
